prog_insmem: RTL and testbench
==============================

# prog_insmem

Loadable, parametrised instruction memory for the single-cycle core. A sequential load port fills it with a program word by word. After that it serves fetches by byte-addressed PC with a registered one-cycle read. It reports misaligned and out-of-program fetches instead of returning garbage. It sits between the PC register and the decoder and replaces the fixed-content instruction ROM.

## Interface
- `DATA_W`, 32, instruction word width in bits.
- `DEPTH`, 64, number of words; power of two, at least 2.
- `NOP_WORD`, 32'h0000_0000, word returned on a fault and after reset.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `ld_valid`  in  1  a load word is offered.
- `ld_data`  in  DATA_W  load word.
- `ld_last`  in  1  the offered word is the last word of the program.
- `ld_ready`  out  1  load word accepted this cycle if `ld_valid` is high.
- `reload`  in  1  single-cycle pulse: discard the program and return to EMPTY.
- `f_req`  in  1  fetch request.
- `pc`  in  32  byte address of the fetch.
- `f_ready`  out  1  the fetch is accepted this cycle if `f_req` is high.
- `f_valid`  out  1  `inscode`/`f_fault` valid; one cycle per accepted fetch.
- `inscode`  out  DATA_W  fetched instruction.
- `f_fault`  out  2  0 = ok, 1 = misaligned, 2 = out of range.
- `loaded`  out  1  state is READY.
- `ld_count`  out  clog2(DEPTH)+1  number of program words held.

## Operation
- FSM states: EMPTY, LOAD, READY.
- EMPTY:
  - `ld_ready`=1, `f_ready`=0.
  - An accepted word is written to mem[0] and sets count=1.
  - Next state is LOAD, or READY if `ld_last` was set.
- LOAD:
  - `ld_ready`=1, `f_ready`=0.
  - An accepted word is written to mem[count], then count is incremented.
  - Go to READY on `ld_last`, or when the DEPTH-th word is accepted (implicit last; a later `ld_last` is not required).
- READY:
  - `ld_ready`=0, `f_ready`=1.
  - `reload` sends the FSM to EMPTY and clears count. Memory contents are kept but become unreachable.
- `reload` in EMPTY or LOAD also clears count and moves the FSM to EMPTY. Any word offered in the same cycle is not written.
- Fetch decode, on acceptance (`f_req` && `f_ready`):
  - idx = `pc`[clog2(DEPTH)+1:2].
  - fault=1 if `pc`[1:0]≠0. This has priority.
  - Otherwise fault=2 if `pc`≥4·count, compared at full 32-bit width. This includes upper bits beyond the array.
  - Otherwise fault=0 and `inscode`=mem[idx].
  - On any fault, `inscode`=`NOP_WORD`.
- When no fetch was accepted in the previous cycle: `f_valid`=0, `f_fault`=0, and `inscode` holds its last value.
- `ld_count` and `loaded` reflect the registered state. They are not combinational on inputs.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state EMPTY, count 0.
  - `f_valid`=0, `f_fault`=0, `inscode`=`NOP_WORD`, `loaded`=0, `ld_count`=0.
  - Memory array is not reset.
- `ld_ready` and `f_ready` are decoded from state only. They do not depend on `ld_valid` or `f_req`.
- Write: a word accepted at edge N is readable by a fetch accepted at edge N+1 or later, once the FSM is in READY.
- Fetch latency: request accepted at edge N gives `f_valid`/`inscode`/`f_fault` registered at edge N, visible during cycle N+1.
- Fetch throughput: one per cycle, back-to-back, no bubbles.
- `reload` together with `f_req` in READY: the fetch is accepted and answered with the pre-reload count; `f_ready`=0 from the next cycle.
- Reset mid-load: the partial program is discarded and count returns to 0.
- Reset mid-fetch: `f_valid` drops immediately.
- `ld_last` while `ld_valid`=0 is ignored.

## Structure
- Shared package `insmem_pkg`:
  - FSM state enum (EMPTY/LOAD/READY).
  - Fault codes FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE.
  - Default `NOP_WORD`.
- One natural sub-module, `insmem_array`: a single-port-write / single-port-read registered RAM of DEPTH×DATA_W with no reset, so it can map to block RAM.
- FSM, counter, address check and output muxing stay in `prog_insmem`.

## Test plan
- Reset then load 3 words (0x11111111, 0x22222222, 0x33333333 with `ld_last` on the third) → `loaded`=1, `ld_count`=3. Fetch `pc`=0,4,8 back-to-back → `f_valid` for 3 consecutive cycles with those words, `f_fault`=0.
- With 3 words loaded: fetch `pc`=12 → `inscode`=`NOP_WORD`, `f_fault`=2. Fetch `pc`=6 → `f_fault`=1. Fetch `pc`=0x100 → `f_fault`=2, not aliased to mem[0].
- Load 64 words with no `ld_last` → READY after the 64th, `ld_ready`=0. A 65th `ld_valid` is ignored. Fetch `pc`=252 returns word 63.
- Fetch attempted in EMPTY and in LOAD → `f_ready`=0, `f_valid` stays 0.
- `reload` pulsed together with `f_req` (`pc`=4) in READY → that fetch answered with word 1. Then `loaded`=0, `ld_count`=0, `f_ready`=0. A new 1-word load gives READY with `ld_count`=1.
- Drive `reset` low after 2 of 4 load words, then release → `ld_count`=0, `inscode`=`NOP_WORD`, state EMPTY. A fresh load works normally.

Source files
------------

// File: rtl/insmem_pkg.sv
// Shared types for the loadable instruction memory: FSM states, fetch fault
// codes and the default word returned on faults and after reset.
package insmem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/insmem_array.sv
// DEPTH x DATA_W RAM, one write port and one registered read port.
// No reset on the storage or the read register so it maps onto block RAM.
module insmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_insmem.sv
// Loadable instruction memory: sequential load port fills the program, then
// byte-addressed fetches are served with a one-cycle registered read.
module prog_insmem
    import insmem_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    input  logic                       reload,
    input  logic                       f_req,
    input  logic [31:0]                pc,
    output logic                       f_ready,
    output logic                       f_valid,
    output logic [DATA_W-1:0]          inscode,
    output logic [1:0]                 f_fault,
    output logic                       loaded,
    output logic [$clog2(DEPTH):0]     ld_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t            state;
    logic [CW-1:0]     count;
    fault_t            fault_q;
    logic              valid_q;
    logic              hold_nop;
    logic [DATA_W-1:0] rd_data;

    logic              ld_fire;
    logic              f_fire;
    logic              last_word;
    logic [AW-1:0]     idx;
    logic [31:0]       limit;
    fault_t            fault_now;

    assign ld_ready  = (state != ST_READY);
    assign f_ready   = (state == ST_READY);
    assign ld_fire   = ld_valid && ld_ready && !reload;
    assign f_fire    = f_req && f_ready;
    // The DEPTH-th accepted word closes the program even without ld_last.
    assign last_word = ld_last || (count == CW'(DEPTH - 1));
    assign idx       = pc[AW+1:2];
    assign limit     = {{(32-CW-2){1'b0}}, count, 2'b00};

    always_comb begin
        fault_now = FAULT_NONE;
        if (pc[1:0] != 2'b00)
            fault_now = FAULT_MISALIGN;
        else if (pc >= limit)
            fault_now = FAULT_RANGE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
            count <= '0;
        end else if (reload) begin
            state <= ST_EMPTY;
            count <= '0;
        end else if (ld_fire) begin
            count <= count + 1'b1;
            state <= last_word ? ST_READY : ST_LOAD;
        end
    end

    // hold_nop remembers whether the last answered fetch faulted, so inscode
    // keeps returning NOP_WORD while idle instead of stale RAM output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            fault_q  <= FAULT_NONE;
            hold_nop <= 1'b1;
        end else begin
            valid_q <= f_fire;
            fault_q <= f_fire ? fault_now : FAULT_NONE;
            if (f_fire) hold_nop <= (fault_now != FAULT_NONE);
        end
    end

    insmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (count[AW-1:0]),
        .wdata (ld_data),
        .re    (f_fire && (fault_now == FAULT_NONE)),
        .raddr (idx),
        .rdata (rd_data)
    );

    assign f_valid  = valid_q;
    assign f_fault  = fault_q;
    assign inscode  = hold_nop ? NOP_WORD : rd_data;
    assign loaded   = (state == ST_READY);
    assign ld_count = count;

endmodule

// File: tb/tb_prog_insmem.sv
// Directed bench for prog_insmem: fetch vector table plus hand-written
// sequences for load, reload and reset corner cases.
module tb_prog_insmem;

    localparam logic [31:0] NOP = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reload;
    logic        f_req;
    logic [31:0] pc;
    logic        f_ready;
    logic        f_valid;
    logic [31:0] inscode;
    logic [1:0]  f_fault;
    logic        loaded;
    logic [6:0]  ld_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [1:0]  fault;
        logic [31:0] code;
    } vec_t;

    vec_t vecs[8];

    prog_insmem #(
        .DATA_W   (32),
        .DEPTH    (64),
        .NOP_WORD (NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .reload   (reload),
        .f_req    (f_req),
        .pc       (pc),
        .f_ready  (f_ready),
        .f_valid  (f_valid),
        .inscode  (inscode),
        .f_fault  (f_fault),
        .loaded   (loaded),
        .ld_count (ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        f_req = 1'b1;
        pc    = a;
        step();
        f_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"range_pc12",   32'd12,         2'd2, NOP};
        vecs[1] = '{"misalign_pc6", 32'd6,          2'd1, NOP};
        vecs[2] = '{"range_pc100",  32'h100,        2'd2, NOP};
        vecs[3] = '{"ok_pc4",       32'd4,          2'd0, 32'h2222_2222};
        vecs[4] = '{"range_top",    32'hFFFF_FFFC,  2'd2, NOP};
        vecs[5] = '{"misalign_pc9", 32'd9,          2'd1, NOP};
        vecs[6] = '{"ok_pc8",       32'd8,          2'd0, 32'h3333_3333};
        vecs[7] = '{"misalign_hi",  32'h8000_0002,  2'd1, NOP};

        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; f_req = 1'b0; pc = '0;
        step(); step();
        chk("rst_count",   ld_count, 0);
        chk("rst_loaded",  loaded,   0);
        chk("rst_fvalid",  f_valid,  0);
        chk("rst_fault",   f_fault,  0);
        chk("rst_inscode", inscode,  NOP);
        reset = 1'b1;
        step();
        chk("empty_ldready", ld_ready, 1);
        chk("empty_fready",  f_ready,  0);

        // fetch attempts in EMPTY and LOAD are never accepted
        fetch(0);
        chk("empty_fetch_valid", f_valid, 0);
        load_word(32'h1111_1111, 0);
        chk("load_fready", f_ready, 0);
        fetch(0);
        chk("load_fetch_valid", f_valid, 0);
        load_word(32'h2222_2222, 0);
        load_word(32'h3333_3333, 1);
        chk("l3_loaded",  loaded,   1);
        chk("l3_count",   ld_count, 3);
        chk("l3_ldready", ld_ready, 0);

        // back-to-back fetches
        f_req = 1'b1; pc = 0;
        step();
        chk("b2b0_valid", f_valid, 1);
        chk("b2b0_code",  inscode, 32'h1111_1111);
        pc = 4;
        step();
        chk("b2b1_valid", f_valid, 1);
        chk("b2b1_code",  inscode, 32'h2222_2222);
        pc = 8;
        step();
        chk("b2b2_valid", f_valid, 1);
        chk("b2b2_code",  inscode, 32'h3333_3333);
        chk("b2b2_fault", f_fault, 0);
        f_req = 1'b0;
        step();
        chk("idle_valid", f_valid, 0);
        chk("idle_hold",  inscode, 32'h3333_3333);

        foreach (vecs[i]) begin
            fetch(vecs[i].pc);
            chk({vecs[i].name, "_valid"}, f_valid, 1);
            chk({vecs[i].name, "_fault"}, f_fault, vecs[i].fault);
            chk({vecs[i].name, "_code"},  inscode, vecs[i].code);
        end
        step();
        chk("idle_after_fault_fault", f_fault, 0);
        chk("idle_after_fault_code",  inscode, NOP);

        // reload together with a fetch: fetch answered with old program
        reload = 1'b1; f_req = 1'b1; pc = 4;
        step();
        reload = 1'b0; f_req = 1'b0;
        chk("rl_valid",  f_valid,  1);
        chk("rl_code",   inscode,  32'h2222_2222);
        chk("rl_fault",  f_fault,  0);
        chk("rl_loaded", loaded,   0);
        chk("rl_count",  ld_count, 0);
        chk("rl_fready", f_ready,  0);

        // ld_last without ld_valid is ignored
        ld_last = 1'b1;
        step();
        ld_last = 1'b0;
        chk("lastnovalid_loaded", loaded,   0);
        chk("lastnovalid_count",  ld_count, 0);

        // reload in LOAD drops the word offered alongside it
        load_word(32'h5555_5555, 0);
        ld_valid = 1'b1; ld_data = 32'h6666_6666; reload = 1'b1;
        step();
        ld_valid = 1'b0; reload = 1'b0;
        chk("rlload_count",   ld_count, 0);
        chk("rlload_ldready", ld_ready, 1);

        load_word(32'hAAAA_AAAA, 1);
        chk("one_loaded", loaded,   1);
        chk("one_count",  ld_count, 1);
        fetch(4);
        chk("one_range", f_fault, 2);
        fetch(0);
        chk("one_code",  inscode, 32'hAAAA_AAAA);
        chk("one_fault", f_fault, 0);

        // full 64-word load, implicit last
        reload = 1'b1;
        step();
        reload = 1'b0;
        for (int i = 0; i < 64; i++) load_word(32'hC000_0000 + i, 0);
        chk("full_loaded",  loaded,   1);
        chk("full_count",   ld_count, 64);
        chk("full_ldready", ld_ready, 0);
        load_word(32'hBAD0_BAD0, 0);
        chk("full_extra_count", ld_count, 64);
        fetch(252);
        chk("full_252_code",  inscode, 32'hC000_003F);
        chk("full_252_fault", f_fault, 0);
        fetch(0);
        chk("full_0_code", inscode, 32'hC000_0000);
        fetch(256);
        chk("full_256_fault", f_fault, 2);
        chk("full_256_code",  inscode, NOP);

        // async reset mid-fetch drops f_valid immediately
        fetch(8);
        chk("prerst_valid", f_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midfetch_rst_valid", f_valid, 0);
        step();
        reset = 1'b1;
        step();

        // reset mid-load discards the partial program
        load_word(32'h0101_0101, 0);
        load_word(32'h0202_0202, 0);
        chk("partial_count", ld_count, 2);
        #2 reset = 1'b0;
        #1;
        chk("midload_rst_count",   ld_count, 0);
        chk("midload_rst_code",    inscode,  NOP);
        chk("midload_rst_loaded",  loaded,   0);
        chk("midload_rst_ldready", ld_ready, 1);
        step();
        reset = 1'b1;
        step();
        load_word(32'h0A0A_0A0A, 0);
        load_word(32'h0B0B_0B0B, 0);
        load_word(32'h0C0C_0C0C, 0);
        load_word(32'h0D0D_0D0D, 1);
        chk("fresh_count", ld_count, 4);
        fetch(12);
        chk("fresh_12_code", inscode, 32'h0D0D_0D0D);
        fetch(4);
        chk("fresh_4_code", inscode, 32'h0B0B_0B0B);
        fetch(16);
        chk("fresh_16_fault", f_fault, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
